// File: rtl/isp_roi_crop.sv
// isp_roi_crop: crops a rectangular region of interest out of a raster pixel stream
//
// Ports:
//   pclk, rst_n             pixel clock, asynchronous active-low reset
//   cfg_en                  1 = crop active, 0 = bypass (captured at frame start)
//   cfg_x0/cfg_y0           window left column / top row, 0-based
//   cfg_w/cfg_h             window width / height
//   in_href/in_vsync/in_data  input line valid, vertical blanking, pixel
//   out_href/out_vsync/out_data  cropped stream, one cycle latency, data zero when idle
//   win_clip                window exceeded the line or frame during the previous frame
//   stat_lines/stat_pixels  output lines / pixels of the previous frame
//
// Optional feature: define ISP_ROI_CROP_STATS_EN to build the frame statistics counters;
// otherwise stat_lines and stat_pixels are tied to zero.
module isp_roi_crop #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     pclk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic [11:0]              cfg_x0,
    input  logic [11:0]              cfg_y0,
    input  logic [11:0]              cfg_w,
    input  logic [11:0]              cfg_h,
    input  logic                     in_href,
    input  logic                     in_vsync,
    input  logic [BITS*CHANNELS-1:0] in_data,
    output logic                     out_href,
    output logic                     out_vsync,
    output logic [BITS*CHANNELS-1:0] out_data,
    output logic                     win_clip,
    output logic [15:0]              stat_lines,
    output logic [31:0]              stat_pixels
);
    localparam int WW = (CNT_W > 13) ? CNT_W : 13;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             vs_d, href_d, armed, sticky;
    logic             sh_en;
    logic [11:0]      sh_x0, sh_y0, sh_w, sh_h;
    logic [CNT_W-1:0] col_q, row_q, col_c, row_c;
    logic             frame_start, line_end, hit, en_e, win_x, win_y, sh_row, line_clip, frame_clip;
    logic [11:0]      x0_e, y0_e, w_e, h_e;
    logic [12:0]      x_end, y_end, sx_end, sy_end;

    assign frame_start = vs_d & ~in_vsync;
    // armed stays low until in_href has been seen low, so a line already in flight
    // at reset release produces neither output nor a row increment
    assign line_end    = href_d & ~in_href & armed;

    // on frame_start the freshly captured configuration and row 0 already apply
    assign en_e  = frame_start ? cfg_en : sh_en;
    assign x0_e  = frame_start ? cfg_x0 : sh_x0;
    assign y0_e  = frame_start ? cfg_y0 : sh_y0;
    assign w_e   = frame_start ? cfg_w  : sh_w;
    assign h_e   = frame_start ? cfg_h  : sh_h;
    assign col_c = href_d ? col_q : '0;
    assign row_c = frame_start ? '0 : row_q;

    assign x_end  = {1'b0, x0_e} + {1'b0, w_e};
    assign y_end  = {1'b0, y0_e} + {1'b0, h_e};
    assign sx_end = {1'b0, sh_x0} + {1'b0, sh_w};
    assign sy_end = {1'b0, sh_y0} + {1'b0, sh_h};

    assign win_x = (WW'(col_c) >= WW'(x0_e)) && (WW'(col_c) < WW'(x_end));
    assign win_y = (WW'(row_c) >= WW'(y0_e)) && (WW'(row_c) < WW'(y_end));
    assign hit   = in_href & armed & (~en_e | (win_x & win_y));

    // col_q holds the pixel count of the line, so at line end it is last column + 1
    assign sh_row     = (WW'(row_q) >= WW'(sh_y0)) && (WW'(row_q) < WW'(sy_end));
    assign line_clip  = line_end & sh_en & sh_row & (WW'(col_q) < WW'(sx_end));
    assign frame_clip = sh_en & (WW'(row_q) < WW'(sy_end));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d     <= 1'b0;
            href_d   <= 1'b0;
            armed    <= 1'b0;
            sticky   <= 1'b0;
            win_clip <= 1'b0;
            out_href <= 1'b0;
            out_data <= '0;
            col_q    <= '0;
            row_q    <= '0;
            sh_en    <= 1'b0;
            sh_x0    <= '0;
            sh_y0    <= '0;
            sh_w     <= '0;
            sh_h     <= '0;
        end else begin
            vs_d     <= in_vsync;
            href_d   <= in_href;
            armed    <= armed | ~in_href;
            out_href <= hit;
            out_data <= hit ? in_data : '0;
            if (in_href)
                col_q <= (col_c == CMAX) ? col_c : col_c + 1'b1;
            row_q <= frame_start ? '0 : (line_end && row_q != CMAX) ? row_q + 1'b1 : row_q;
            if (frame_start) begin
                sh_en    <= cfg_en;
                sh_x0    <= cfg_x0;
                sh_y0    <= cfg_y0;
                sh_w     <= cfg_w;
                sh_h     <= cfg_h;
                win_clip <= sticky | line_clip | frame_clip;
                sticky   <= 1'b0;
            end else if (line_clip) begin
                sticky <= 1'b1;
            end
        end
    end

    assign out_vsync = vs_d;

`ifdef ISP_ROI_CROP_STATS_EN
    logic [15:0] cnt_lines;
    logic [31:0] cnt_pixels;

    // a hit following an idle output cycle starts a new output line
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lines   <= '0;
            cnt_pixels  <= '0;
            stat_lines  <= '0;
            stat_pixels <= '0;
        end else if (frame_start) begin
            stat_lines  <= cnt_lines;
            stat_pixels <= cnt_pixels;
            cnt_lines   <= '0;
            cnt_pixels  <= '0;
        end else begin
            if (hit && !out_href && cnt_lines != '1)
                cnt_lines <= cnt_lines + 1'b1;
            if (hit && cnt_pixels != '1)
                cnt_pixels <= cnt_pixels + 1'b1;
        end
    end
`else
    assign stat_lines  = '0;
    assign stat_pixels = '0;
`endif

endmodule
